// File: rtl/barrel_shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the result consumer and the arbiter.
// Latency: none, wires only.
// Backpressure: the ready signals carry it; data and amt hold while valid waits for ready.
interface barrel_shift_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [63:0] req0_data;
   logic [5:0]  req0_amt;
   logic        req1_valid;
   logic        req1_ready;
   logic [63:0] req1_data;
   logic [5:0]  req1_amt;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic        res_id;

   // Requester/consumer side.
   modport master (
      output req0_valid, req0_data, req0_amt,
      output req1_valid, req1_data, req1_amt,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req0_amt,
      input  req1_valid, req1_data, req1_amt,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id
   );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Combinational 64-bit arithmetic right shifter, 0..31 positions.
// Latency: 0 cycles.
// Backpressure: none, pure logic.
module bsa_asr64 (
   input  logic [63:0] din,
   input  logic [4:0]  amt,
   output logic [63:0] dout
);
   assign dout = $signed(din) >>> amt;
endmodule

// Two-requester round-robin front end that time-shares one 0..31 shifter for 0..63 shifts.
// Latency: accept edge, then 1..3 shift passes; result valid after the last pass.
// Backpressure: result is held in DONE until res_ready; no new accept outside IDLE.
module barrel_shift_arbiter #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   barrel_shift_arbiter_if.slave     bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] data_q, data_d;
   logic [5:0]  rem_q, rem_d;
   logic        id_q, id_d;
   logic        last_q, last_d;

   logic [4:0]  step;
   logic [5:0]  rem_next;
   logic [63:0] shift_out;
   logic        gnt;
   logic        ready0;
   logic        ready1;
   logic        res_vld;

   // Each pass takes at most 31 positions; anything left waits for the next pass.
   always_comb begin
      step     = (rem_q > 6'd31) ? 5'd31 : rem_q[4:0];
      rem_next = rem_q - {1'b0, step};
   end

   bsa_asr64 u_shifter (
      .din  (data_q),
      .amt  (step),
      .dout (shift_out)
   );

   // Next-state and handshake decode; ties go to the requester not served last.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      id_d    = id_q;
      last_d  = last_q;
      ready0  = 1'b0;
      ready1  = 1'b0;
      res_vld = 1'b0;
      gnt     = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

      case (state_q)
         IDLE: begin
            // Readies are gated by rst so they read 0 while reset is held.
            ready0 = bus.req0_valid & ~gnt & ~rst;
            ready1 = bus.req1_valid &  gnt & ~rst;
            if (ready0 || ready1) begin
               data_d  = gnt ? bus.req1_data : bus.req0_data;
               rem_d   = gnt ? bus.req1_amt  : bus.req0_amt;
               id_d    = gnt;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // amt 0 still passes through once with step 0.
            data_d = shift_out;
            rem_d  = rem_next;
            if (rem_next == 6'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            res_vld = 1'b1;
            if (bus.res_ready) begin
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight operation and restores priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= 64'd0;
         rem_q   <= 6'd0;
         id_q    <= 1'b0;
         last_q  <= ~RR_INIT;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.res_valid  = res_vld;
   assign bus.res_data   = data_q;
   assign bus.res_id     = id_q;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for the shared barrel shift arbiter.
// Latency: checks pass counts of 1, 2 and 3 and the k+2 operation period.
// Backpressure: holds res_ready low in DONE and checks the outputs freeze.
module tb_barrel_shift_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   barrel_shift_arbiter_if bus();

   barrel_shift_arbiter #(.RR_INIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one operation from IDLE; passes = -1 on timeout.
   task automatic run_op(input bit id, input logic [63:0] d, input logic [5:0] a,
                         output int passes, output logic [63:0] rd, output logic rid);
      bit got;
      passes = -1;
      rd     = 64'd0;
      rid    = 1'b0;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = a;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = a;
      end
      bus.res_ready = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!got) begin
         bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      got = 1'b0;
      for (int n = 1; n <= 10 && !got; n++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            got = 1'b1; passes = n - 1; rd = bus.res_data; rid = bus.res_id;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b exp=0", bus.req0_ready); end
      total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%b exp=0", bus.req1_ready); end
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
      total++; if (bus.res_data !== 64'd0) begin bad++; $display("FAIL reset_res_data got=%h exp=0", bus.res_data); end
      total++; if (bus.res_id !== 1'b0) begin bad++; $display("FAIL reset_res_id got=%b exp=0", bus.res_id); end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL idle_res_valid got=%b exp=0", bus.res_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int p; logic [63:0] rd; logic rid;
      run_op(1'b0, 64'h8000_0000_0000_0000, 6'd4, p, rd, rid);
      total++; if (p !== 1) begin bad++; $display("FAIL single_passes got=%0d exp=1", p); end
      total++; if (rd !== 64'hF800_0000_0000_0000) begin bad++; $display("FAIL single_data got=%h exp=f800000000000000", rd); end
      total++; if (rid !== 1'b0) begin bad++; $display("FAIL single_id got=%b exp=0", rid); end
   endtask

   task automatic test_two_pass();
      int p; logic [63:0] rd; logic rid;
      run_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 6'd40, p, rd, rid);
      total++; if (p !== 2) begin bad++; $display("FAIL two_passes got=%0d exp=2", p); end
      total++; if (rd !== 64'h0000_0000_007F_FFFF) begin bad++; $display("FAIL two_data got=%h exp=00000000007fffff", rd); end
      total++; if (rid !== 1'b1) begin bad++; $display("FAIL two_id got=%b exp=1", rid); end
   endtask

   task automatic test_three_pass();
      int p; logic [63:0] rd; logic rid;
      run_op(1'b0, 64'h8000_0000_0000_0000, 6'd63, p, rd, rid);
      total++; if (p !== 3) begin bad++; $display("FAIL neg63_passes got=%0d exp=3", p); end
      total++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL neg63_data got=%h exp=ffffffffffffffff", rd); end
      run_op(1'b0, 64'h4000_0000_0000_0000, 6'd63, p, rd, rid);
      total++; if (p !== 3) begin bad++; $display("FAIL pos63_passes got=%0d exp=3", p); end
      total++; if (rd !== 64'd0) begin bad++; $display("FAIL pos63_data got=%h exp=0", rd); end
      run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 6'd0, p, rd, rid);
      total++; if (p !== 1) begin bad++; $display("FAIL amt0_passes got=%0d exp=1", p); end
      total++; if (rd !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL amt0_data got=%h exp=123456789abcdef0", rd); end
   endtask

   task automatic test_arbitration();
      int ngr; int both; int last_cyc;
      logic [3:0] order;
      ngr = 0; both = 0; last_cyc = -1; order = 4'd0;
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_data = 64'h8000_0000_0000_0000; bus.req0_amt = 6'd0;
      bus.req1_valid = 1'b1; bus.req1_data = 64'h0000_0000_0000_0040; bus.req1_amt = 6'd2;
      bus.res_ready  = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
         @(negedge clk);
         if (bus.req0_ready && bus.req1_ready) both++;
         if (bus.req0_ready || bus.req1_ready) begin
            order[ngr] = bus.req1_ready;
            if (last_cyc >= 0) begin
               total++; if (cyc - last_cyc !== 3) begin bad++; $display("FAIL arb_period got=%0d exp=3", cyc - last_cyc); end
            end
            last_cyc = cyc;
            ngr++;
         end
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (ngr !== 4) begin bad++; $display("FAIL arb_grants got=%0d exp=4", ngr); end
      total++; if (order !== 4'b1010) begin bad++; $display("FAIL arb_order got=%b exp=1010 (msb=4th)", order); end
      total++; if (both !== 0) begin bad++; $display("FAIL arb_two_ready got=%0d exp=0", both); end
   endtask

   task automatic test_backpressure();
      bit got;
      bus.req0_valid = 1'b1; bus.req0_data = 64'h8000_0000_0000_0000; bus.req0_amt = 6'd4;
      bus.res_ready  = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.req0_ready) got = 1'b1; else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      bus.req0_data = 64'h0000_0000_0000_0010;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (bus.res_valid) got = 1'b1; else begin @(posedge clk); #1; end
      end
      total++; if (!got) begin bad++; $display("FAIL bp_res_valid got=0 exp=1"); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (bus.res_valid !== 1'b1 || bus.res_data !== 64'hF800_0000_0000_0000 || bus.res_id !== 1'b0)
            begin bad++; $display("FAIL bp_hold got=%b/%h/%b exp=1/f800000000000000/0", bus.res_valid, bus.res_data, bus.res_id); end
         total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", bus.req0_ready); end
         @(posedge clk); #1;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_done got=%b exp=0", bus.req0_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0 || bus.req0_ready !== 1'b1)
         begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", bus.res_valid, bus.req0_ready); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (bus.res_valid) got = 1'b1; else begin @(posedge clk); #1; end
      end
      total++; if (bus.res_data !== 64'd1) begin bad++; $display("FAIL bp_second got=%h exp=1", bus.res_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift();
      bit got; int seen;
      bus.req1_valid = 1'b1; bus.req1_data = 64'h7FFF_FFFF_FFFF_FFFF; bus.req1_amt = 6'd40;
      bus.res_ready  = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.req1_ready) got = 1'b1; else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      #2;
      bus.req0_valid = 1'b1; bus.req0_data = 64'h0000_0000_0000_0100; bus.req0_amt = 6'd8;
      bus.req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 64'd0 || bus.res_id !== 1'b0)
         begin bad++; $display("FAIL mid_rst_outputs got=%b/%h/%b exp=0/0/0", bus.res_valid, bus.res_data, bus.res_id); end
      total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
         begin bad++; $display("FAIL mid_rst_ready got=%b/%b exp=0/0", bus.req0_ready, bus.req1_ready); end
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.res_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_no_result got=%0d exp=0", seen); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
         begin bad++; $display("FAIL mid_rst_rr got=%b/%b exp=1/0", bus.req0_ready, bus.req1_ready); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (bus.res_valid) got = 1'b1; else begin @(posedge clk); #1; end
      end
      total++; if (!got || bus.res_id !== 1'b0 || bus.res_data !== 64'd1)
         begin bad++; $display("FAIL mid_rst_next got=%b/%b/%h exp=1/0/1", got, bus.res_id, bus.res_data); end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0;
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_data = 64'd0; bus.req0_amt = 6'd0;
      bus.req1_valid = 1'b0; bus.req1_data = 64'd0; bus.req1_amt = 6'd0;
      bus.res_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_two_pass();
      test_three_pass();
      test_arbitration();
      test_backpressure();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
